// File: rtl/window_frame_reader_if.sv
// Sample bus between the Hann window stage, the frame buffer and the FFT.
// Write side: in_sample/in_valid (no backpressure). Read side: out_sample/out_valid/out_ready/out_last.
// overflow pulses once per input sample the frame buffer had to drop.
interface window_frame_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_sample;
    logic             in_valid;
    logic [WIDTH-1:0] out_sample;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             overflow;

    // Environment side: produces input samples, consumes frames.
    modport master (
        output in_sample,
        output in_valid,
        output out_ready,
        input  out_sample,
        input  out_valid,
        input  out_last,
        input  overflow
    );

    // Frame buffer side.
    modport slave (
        input  in_sample,
        input  in_valid,
        input  out_ready,
        output out_sample,
        output out_valid,
        output out_last,
        output overflow
    );
endinterface

// File: rtl/window_frame_reader.sv
// Ping-pong frame buffer: collects FRAME_LEN windowed samples per bank and streams whole frames to the FFT.
// Latency: first out_valid 4 cycles after the in_valid that completes a frame; then one sample per cycle.
// Backpressure: out_ready stalls the two-stage read pipe; input is never stalled, excess samples are dropped (overflow).
//
// Ports: clk_in (rising edge), rst_in (synchronous, active-low), bus (window_frame_reader_if.slave),
//        drop_count[15:0] only when WFR_DROP_COUNT_EN is defined (saturating dropped-sample count).
module window_frame_reader #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    window_frame_reader_if.slave  bus
`ifdef WFR_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    localparam int                IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [0:0] W_FILL  = 1'b0;
    localparam logic [0:0] W_STALL = 1'b1;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_PRIME  = 2'd1;
    localparam logic [1:0] R_STREAM = 2'd2;

    // Both banks in one array; the bank select is the top address bit.
    logic [WIDTH-1:0] mem [0:2*FRAME_LEN-1];
    logic [1:0]       bank_full;

    logic [0:0]       wr_state;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;

    logic [1:0]       rd_state;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_issue_done;

    // Stage 1: registered memory read. Stage 2: output register.
    logic [WIDTH-1:0] rd_dat;
    logic             rd_vld;
    logic             rd_last;
    logic [WIDTH-1:0] out_sample_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             overflow_q;

    logic wr_en, wr_done, drop, frame_done, advance, rd_issue, other_free;

    assign wr_en      = (wr_state == W_FILL) && bus.in_valid;
    assign wr_done    = wr_en && (wr_idx == LAST_IDX);
    assign drop       = (wr_state == W_STALL) && bus.in_valid;
    assign frame_done = out_valid_q && bus.out_ready && out_last_q;
    // The whole pipe moves together; when the output is held, the read stage holds too.
    assign advance    = !out_valid_q || bus.out_ready;
    assign rd_issue   = advance &&
                        ((rd_state == R_PRIME) || ((rd_state == R_STREAM) && !rd_issue_done));
    // The stalled writer may leave as soon as the reader releases the other bank at this edge;
    // the sample arriving in that same cycle is still dropped.
    assign other_free = !bank_full[!wr_bank] || (frame_done && (rd_bank == !wr_bank));

    // Bank storage: no reset, contents are only meaningful once a bank is marked FULL.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= bus.in_sample;
        end
        if (rd_issue) begin
            rd_dat <= mem[{rd_bank, rd_idx}];
        end
    end

    // Bank status: writer and reader always touch different banks at any one edge.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bank_full <= 2'b00;
        end else begin
            if (wr_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (frame_done) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    // Writer
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_state   <= W_FILL;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            case (wr_state)
                W_FILL: begin
                    if (bus.in_valid) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            if (!bank_full[!wr_bank]) begin
                                wr_bank <= !wr_bank;
                            end else begin
                                wr_state <= W_STALL;
                            end
                        end
                    end
                end
                W_STALL: begin
                    if (other_free) begin
                        wr_state <= W_FILL;
                        wr_bank  <= !wr_bank;
                    end
                end
                default: wr_state <= W_FILL;
            endcase
        end
    end

    // Reader. Banks alternate strictly, so rd_bank always points at the oldest frame.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_state      <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_idx        <= '0;
            rd_issue_done <= 1'b0;
            rd_vld        <= 1'b0;
            rd_last       <= 1'b0;
            out_sample_q  <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            if (advance) begin
                if (rd_vld) begin
                    out_sample_q <= rd_dat;
                end
                out_valid_q <= rd_vld;
                out_last_q  <= rd_last;
                rd_vld      <= rd_issue;
                rd_last     <= rd_issue && (rd_idx == LAST_IDX);
            end

            case (rd_state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state <= R_PRIME;
                    end
                end
                R_PRIME: begin
                    if (rd_issue) begin
                        rd_idx   <= rd_idx + 1'b1;
                        rd_state <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (rd_issue) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == LAST_IDX) begin
                            rd_issue_done <= 1'b1;
                        end
                    end
                    // Last sample leaves only after every read was issued, so no overlap with rd_issue.
                    if (frame_done) begin
                        rd_bank       <= !rd_bank;
                        rd_idx        <= '0;
                        rd_issue_done <= 1'b0;
                        rd_state      <= bank_full[!rd_bank] ? R_PRIME : R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef WFR_DROP_COUNT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            drop_count <= 16'd0;
        end else if (frame_done) begin
            drop_count <= 16'd0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

    assign bus.out_sample = out_sample_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.overflow   = overflow_q;

endmodule
